// File: rtl/divider.sv
// Multi-cycle 32-bit signed/unsigned restoring divider: result = {remainder, quotient}.
// 33 edges from accept to ready (2 for a zero divisor); result held while start stays high.
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic        start,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic [31:0] rem_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic        op1_neg;
    logic        op2_neg;
    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        qbit;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        op1_neg = signed_div & operand_1[31];
        op2_neg = signed_div & operand_2[31];
        op1_mag = op1_neg ? (~operand_1 + 32'd1) : operand_1;
        op2_mag = op2_neg ? (~operand_2 + 32'd1) : operand_2;

        // The dividend register doubles as the quotient shift register: each step
        // consumes its MSB and shifts the new quotient bit into the LSB.
        trial   = {rem_q, dvd_q[31]};
        diff    = trial - {1'b0, dvs_q};
        qbit    = (trial >= {1'b0, dvs_q});
        rem_d   = qbit ? diff[31:0] : trial[31:0];
        quo_d   = {dvd_q[30:0], qbit};
        quo_fix = q_neg_q ? (~quo_d + 32'd1) : quo_d;
        rem_fix = r_neg_q ? (~rem_d + 32'd1) : rem_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            dvd_q    <= 32'd0;
            dvs_q    <= 32'd0;
            rem_q    <= 32'd0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q  <= 1'b0;
                    result_q <= 64'd0;
                    if (start && !annul) begin
                        dvd_q   <= op1_mag;
                        dvs_q   <= op2_mag;
                        rem_q   <= 32'd0;
                        q_neg_q <= op1_neg ^ op2_neg;
                        r_neg_q <= op1_neg;
                        cnt_q   <= 5'd0;
                        state_q <= (operand_2 == 32'd0) ? BY_ZERO : ON;
                    end
                end
                BY_ZERO: begin
                    if (annul) begin
                        state_q <= IDLE;
                    end else begin
                        state_q  <= END;
                        ready_q  <= 1'b1;
                        result_q <= 64'd0;
                    end
                end
                ON: begin
                    if (annul) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= quo_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q  <= END;
                            ready_q  <= 1'b1;
                            result_q <= {rem_fix, quo_fix};
                        end
                    end
                end
                END: begin
                    if (!start || annul) begin
                        state_q  <= IDLE;
                        ready_q  <= 1'b0;
                        result_q <= 64'd0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_divider.sv
// Randomised scoreboard bench for the divider: stimulus pushes expected results,
// a negedge monitor pops and compares whenever ready rises.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] res;
        int          at;
    } exp_t;

    exp_t        sbq[$];
    exp_t        cur;
    logic [63:0] held = 64'd0;
    logic        prev_ready = 1'b0;

    divider dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: divide magnitudes, then apply the sign rules; zero divisor gives 0.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        logic        na, nb;
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) return 64'd0;
        na = sd & a[31];
        nb = sd & b[31];
        ma = na ? (~a + 32'd1) : a;
        mb = nb ? (~b + 32'd1) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (na ^ nb) q = ~q + 32'd1;
        if (na)      r = ~r + 32'd1;
        return {r, q};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            prev_ready = 1'b0;
        end else begin
            if (ready && !prev_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: ready=1 result=%h, required ready=0", result);
                end else begin
                    cur = sbq.pop_front();
                    check64("result", result, cur.res);
                    check64("latency_cycle", 64'(cyc), 64'(cur.at));
                    held = cur.res;
                end
            end else if (ready) begin
                check64("result_hold", result, held);
            end else begin
                check64("idle_result_zero", result, 64'd0);
            end
            prev_ready = ready;
        end
    end

    // Called just after a negedge; returns just after a negedge with the DUT back in IDLE.
    task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv, input int hold, input bit end_by_annul);
        int acc;
        bit done;
        signed_div = sd;
        operand_1  = a;
        operand_2  = b;
        start      = 1'b1;
        annul      = 1'b0;
        acc        = cyc + 1;
        sbq.push_back('{expv, acc + ((b == 32'd0) ? 1 : 32)});
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ready) begin
                done = 1'b1;
            end else begin
                operand_1  = $urandom;
                operand_2  = $urandom;
                signed_div = 1'($urandom);
                if (b != 32'd0 && cyc < acc + 28) start = 1'($urandom);
                else start = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=0 after 40 cycles, required 1");
        end
        repeat (hold) @(negedge clk);
        if (end_by_annul) annul = 1'b1;
        else start = 1'b0;
        @(negedge clk);
        check64("release_ready", {63'd0, ready}, 64'd0);
        annul = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        logic        sd;
        logic [31:0] a, b;
        int          sel;
        bit          done;

        rst        = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        operand_1  = 32'd0;
        operand_2  = 32'd0;
        #1;
        check64("reset_ready", {63'd0, ready}, 64'd0);
        check64("reset_result", result, 64'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 2, 1'b0);
        do_div(1'b1, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 1, 1'b0);
        do_div(1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 0, 1'b1);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 3, 1'b0);
        do_div(1'b0, 32'd1234, 32'd0, 64'd0, 1, 1'b0);
        do_div(1'b1, 32'h80000000, 32'd0, 64'd0, 0, 1'b0);

        // Annul on the 10th ON cycle, then an immediate 9/3.
        signed_div = 1'b0;
        operand_1  = 32'd12345678;
        operand_2  = 32'd11;
        start      = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        check64("annul_ready", {63'd0, ready}, 64'd0);
        do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1, 1'b0);

        // Reset on the 20th ON cycle: outputs zero without a clock edge.
        signed_div = 1'b0;
        operand_1  = 32'd1000;
        operand_2  = 32'd3;
        start      = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        start = 1'b0;
        #1;
        check64("rst_on_ready", {63'd0, ready}, 64'd0);
        check64("rst_on_result", result, 64'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (5) @(negedge clk);
        check64("post_rst_idle", {63'd0, ready}, 64'd0);

        // Reset while a finished result is held.
        signed_div = 1'b0;
        operand_1  = 32'd77;
        operand_2  = 32'd5;
        start      = 1'b1;
        sbq.push_back('{model(1'b0, 32'd77, 32'd5), cyc + 33});
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ready) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout_end: ready=0 after 40 cycles, required 1");
        end
        #2 rst = 1'b0;
        start = 1'b0;
        #1;
        check64("rst_end_ready", {63'd0, ready}, 64'd0);
        check64("rst_end_result", result, 64'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);

        repeat (30) begin
            sd  = 1'($urandom);
            a   = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = 32'd0;
            else if (sel < 3)  b = $urandom_range(1, 15);
            else if (sel == 3) b = 32'hFFFFFFFF;
            else               b = $urandom;
            do_div(sd, a, b, model(sd, a, b), $urandom_range(0, 3), 1'($urandom));
        end

        repeat (2) @(negedge clk);
        check64("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have no parameters; every data port SHALL be 32 bits wide (`DATA_BUS`), and `result` SHALL be 64 bits wide (`DOUBLE_DATA_BUS`).
REQ-002 The block SHALL have one clock and SHALL use an asynchronous, active-low reset, with ports named as follows.
REQ-003 clk  input  1 -- the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1 -- asynchronous, active-low reset.
REQ-005 signed_div  input  1 -- 1 selects a signed divide (DIV); 0 selects an unsigned divide (DIVU).
REQ-006 operand_1  input  32 -- dividend.
REQ-007 operand_2  input  32 -- divisor.
REQ-008 start  input  1 -- divide request from EX, held high until the result has been consumed.
REQ-009 annul  input  1 -- cancels any in-flight divide (pipeline flush).
REQ-010 result  output  64 -- {remainder[63:32], quotient[31:0]}, to be written to HI/LO.
REQ-011 ready  output  1 -- result valid; EX drops its stall request when this is high.

Function
REQ-012 The FSM SHALL have four states: IDLE, BY_ZERO, ON, END; all outputs SHALL be registered.
REQ-013 In IDLE, with start=1 and annul=0 at a rising edge (the accept edge), the block SHALL latch operand_1, operand_2 and signed_div; later changes to these inputs SHALL be ignored until the next IDLE.
REQ-014 On the accept edge, a divisor of 0 SHALL cause IDLE->BY_ZERO; otherwise IDLE->ON with the iteration counter cleared to 0.
REQ-015 With start=0 or annul=1 in IDLE, the state SHALL remain IDLE, with ready=0 and result=0.
REQ-016 For a signed divide, the block SHALL store the two's-complement magnitudes of negative operands; for an unsigned divide, it SHALL store the operands as-is.
REQ-017 ON SHALL perform one restoring shift-subtract step per edge (33-bit compare of the partial remainder against the divisor), producing one quotient bit per edge, MSB first.
REQ-018 After the 32nd ON step, the block SHALL go ON->END and load result; ready SHALL be 1 from the cycle after the 33rd edge, counting the accept edge as the first.
REQ-019 Signed fixup (applied on the ON->END transition): the quotient SHALL be negated if the latched operand signs differ; the remainder SHALL be negated if the dividend was negative.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0, with no exception and no special handling.
REQ-021 BY_ZERO SHALL go to END on the next edge with result=0; ready SHALL be 1 after 2 edges from accept.
REQ-022 annul=1 in ON or BY_ZERO SHALL force IDLE on the next edge; ready and result SHALL stay 0, and any partial result SHALL be discarded.
REQ-023 END SHALL hold ready=1 and result stable while start=1 and annul=0.
REQ-024 In END, start=0 or annul=1 SHALL force END->IDLE on the next edge, clearing ready to 0 and result to 0.
REQ-025 A new request SHALL be accepted only from IDLE; the minimum spacing between accept edges SHALL be 35 edges (nonzero divisor).
REQ-026 start dropping while in ON SHALL NOT abort the divide; only annul or rst SHALL abort it.

Reset
REQ-027 rst=0 SHALL immediately (asynchronously) force: state IDLE, counter 0, ready 0, result 0, and all latched operands 0.
REQ-028 Reset asserted mid-divide SHALL discard the operation; after release, the block SHALL wait in IDLE for a fresh start.

Verification
REQ-029 Unsigned 100/7 (start held) -> ready rises 33 edges after accept; result=0x00000002_0000000E.
REQ-030 Signed 0xFFFFFFF9 / 0x00000002 -> result=0xFFFFFFFF_FFFFFFFD; unsigned 0xFFFFFFFF/0x10 -> result=0x0000000F_0FFFFFFF.
REQ-031 Signed 0x80000000 / 0xFFFFFFFF -> result=0x00000000_80000000 after 33 edges.
REQ-032 Divisor 0 (either mode) -> ready=1 after 2 edges, result=0; start dropped -> ready=0 next cycle, IDLE.
REQ-033 Annul asserted on the 10th ON cycle -> IDLE next edge, ready never rises; an immediately following 9/3 request -> result=0x00000000_00000003.
REQ-034 rst pulled low on the 20th ON cycle -> ready=0 and result=0 at once, with no clock edge needed; after release, the block stays idle until start.
